// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared slot type and helpers for the forwarding/hazard controller
package pipe_pkg;

    localparam int MAX_AW      = 8;
    localparam int SEL_REGFILE = 0;

    // rd is stored at MAX_AW bits so one slot type serves every AW <= MAX_AW
    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_writes(input slot_t s, input logic [MAX_AW-1:0] r);
        return s.valid && s.we && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-side request and hazard/forward response bundle
interface fwd_hazard_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int AW      = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1)
);
    logic                     id_valid;
    logic [AW-1:0]            id_rd;
    logic                     id_regwrite;
    logic                     id_is_load;
    logic [NUM_SRC*AW-1:0]    id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic                     flush;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [15:0]              stall_cycles;

    modport master (
        output id_valid, id_rd, id_regwrite, id_is_load, id_rs, id_rs_used, flush,
        input  stall, fwd_sel, stall_cycles
    );

    modport slave (
        input  id_valid, id_rd, id_regwrite, id_is_load, id_rs, id_rs_used, flush,
        output stall, fwd_sel, stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// rtl/fwd_hazard_ctrl_fwd_match.sv - nearest in-flight writer search for one source register
module fwd_match
    import pipe_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  slot_t             slots [N],
    input  logic [MAX_AW-1:0] src,
    input  logic              used,
    output logic              hit,
    output logic [PW-1:0]     pos
);

    // Scan oldest to youngest so the youngest (lowest index) match overwrites the rest
    always_comb begin
        hit = 1'b0;
        pos = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (used && slot_writes(slots[j], src)) begin
                hit = 1'b1;
                pos = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - shadow writer pipeline producing load-use stall and registered forward selects
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int AW       = 5
) (
    input logic         clk,
    input logic         rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slot_t                    ex_q;
    slot_t                    p_q [1:DEPTH];
    slot_t                    search [DEPTH];
    slot_t                    id_slot;
    logic [NUM_SRC-1:0]       src_stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_next;
    logic [NUM_SRC*SEL_W-1:0] fwd_q;
    logic [15:0]              stall_cnt;
    logic                     stall;
    logic                     take;

    // Position 0 is EX; position k is p[k]. The same window is next cycle's p[k+1].
    always_comb begin
        search[0] = ex_q;
        for (int k = 1; k < DEPTH; k++) begin
            search[k] = p_q[k];
        end
    end

    always_comb begin
        id_slot.valid   = bus.id_valid;
        id_slot.rd      = MAX_AW'(bus.id_rd);
        id_slot.we      = bus.id_regwrite;
        id_slot.is_load = bus.id_is_load;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [MAX_AW-1:0] src;
        logic              s_hit;
        logic              f_hit;
        logic [PW-1:0]     s_pos;
        logic [PW-1:0]     f_pos;
        logic              s_load;

        assign src = MAX_AW'(bus.id_rs[i*AW +: AW]);

        fwd_match #(.N(DEPTH)) u_stall_match (
            .slots (search),
            .src   (src),
            .used  (bus.id_rs_used[i]),
            .hit   (s_hit),
            .pos   (s_pos)
        );

        fwd_match #(.N(DEPTH)) u_fwd_match (
            .slots (search),
            .src   (src),
            .used  (bus.id_rs_used[i]),
            .hit   (f_hit),
            .pos   (f_pos)
        );

        // A load at position k has its data available once it reaches p[LOAD_LAT]
        assign s_load       = search[s_pos].is_load;
        assign src_stall[i] = s_hit && s_load && ((int'(s_pos) + 1) < LOAD_LAT);
        assign fwd_next[i*SEL_W +: SEL_W] = f_hit ? (SEL_W'(f_pos) + SEL_W'(1))
                                                  : SEL_W'(SEL_REGFILE);
    end

    assign stall = bus.id_valid && !bus.flush && (|src_stall);
    assign take  = bus.id_valid && !stall && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= SLOT_BUBBLE;
            for (int k = 1; k <= DEPTH; k++) begin
                p_q[k] <= SLOT_BUBBLE;
            end
            fwd_q     <= '0;
            stall_cnt <= '0;
        end else begin
            // A flushed EX instruction leaves as a bubble; older stages keep going
            p_q[1] <= bus.flush ? SLOT_BUBBLE : ex_q;
            for (int k = 1; k < DEPTH; k++) begin
                p_q[k+1] <= p_q[k];
            end
            ex_q  <= take ? id_slot : SLOT_BUBBLE;
            fwd_q <= take ? fwd_next : '0;
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.fwd_sel      = fwd_q;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl over three pipeline shapes
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         tgt;
    logic       id_valid;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       flush;

    logic        obs_stall;
    logic [7:0]  obs_fwd;
    logic [15:0] obs_sc;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    int         exp_sc [3];

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.NUM_SRC(2), .DEPTH(2),  .AW(5)) ifa ();
    fwd_hazard_ctrl_if #(.NUM_SRC(2), .DEPTH(3),  .AW(5)) ifb ();
    fwd_hazard_ctrl_if #(.NUM_SRC(2), .DEPTH(15), .AW(5)) ifs ();

    assign ifa.id_valid    = id_valid && (tgt == 0);
    assign ifa.flush       = flush && (tgt == 0);
    assign ifa.id_rd       = id_rd;
    assign ifa.id_regwrite = id_regwrite;
    assign ifa.id_is_load  = id_is_load;
    assign ifa.id_rs       = id_rs;
    assign ifa.id_rs_used  = id_rs_used;

    assign ifb.id_valid    = id_valid && (tgt == 1);
    assign ifb.flush       = flush && (tgt == 1);
    assign ifb.id_rd       = id_rd;
    assign ifb.id_regwrite = id_regwrite;
    assign ifb.id_is_load  = id_is_load;
    assign ifb.id_rs       = id_rs;
    assign ifb.id_rs_used  = id_rs_used;

    assign ifs.id_valid    = id_valid && (tgt == 2);
    assign ifs.flush       = flush && (tgt == 2);
    assign ifs.id_rd       = id_rd;
    assign ifs.id_regwrite = id_regwrite;
    assign ifs.id_is_load  = id_is_load;
    assign ifs.id_rs       = id_rs;
    assign ifs.id_rs_used  = id_rs_used;

    fwd_hazard_ctrl #(.NUM_SRC(2), .DEPTH(2), .LOAD_LAT(2), .AW(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    fwd_hazard_ctrl #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(3), .AW(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );
    fwd_hazard_ctrl #(.NUM_SRC(2), .DEPTH(15), .LOAD_LAT(15), .AW(5)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );

    always_comb begin
        obs_stall = 1'b0;
        obs_fwd   = '0;
        obs_sc    = '0;
        case (tgt)
            0: begin
                obs_stall = ifa.stall;
                obs_fwd   = {2'b00, ifa.fwd_sel[3:2], 2'b00, ifa.fwd_sel[1:0]};
                obs_sc    = ifa.stall_cycles;
            end
            1: begin
                obs_stall = ifb.stall;
                obs_fwd   = {2'b00, ifb.fwd_sel[3:2], 2'b00, ifb.fwd_sel[1:0]};
                obs_sc    = ifb.stall_cycles;
            end
            default: begin
                obs_stall = ifs.stall;
                obs_fwd   = ifs.fwd_sel;
                obs_sc    = ifs.stall_cycles;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that moved the instruction into EX
    task automatic issue(input string tag, input int t, input logic [4:0] rd, input logic we,
                         input logic ld, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [3:0] ef0, input logic [3:0] ef1,
                         input int est);
        int         n;
        logic [7:0] e;
        tgt         = t;
        id_valid    = 1'b1;
        id_rd       = rd;
        id_regwrite = we;
        id_is_load  = ld;
        id_rs       = {rs1, rs0};
        id_rs_used  = used;
        flush       = 1'b0;
        exp_q.push_back({ef1, ef0});
        exp_sc[t] += est;
        n = 0;
        @(negedge clk);
        while (obs_stall && n <= 40) begin
            n++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        chk({tag, ".stalls"}, 32'(n), 32'(est));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".fwd"}, 32'(obs_fwd), 32'(e));
    endtask

    task automatic bubble(input string tag, input int t);
        logic [7:0] e;
        tgt      = t;
        id_valid = 1'b0;
        flush    = 1'b0;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".fwd"}, 32'(obs_fwd), 32'(e));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        tgt         = 0;
        id_valid    = 1'b1;
        id_rd       = 5'd5;
        id_regwrite = 1'b1;
        id_is_load  = 1'b0;
        id_rs       = {5'd5, 5'd5};
        id_rs_used  = 2'b11;
        flush       = 1'b0;
        exp_sc      = '{0, 0, 0};

        #12;
        chk("rst.stall", 32'(obs_stall), 32'd0);
        chk("rst.fwd",   32'(obs_fwd),   32'd0);
        chk("rst.sc",    32'(obs_sc),    32'd0);
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DEPTH=2, LOAD_LAT=2: ALU forwarding, distance, nearest-wins
        issue("a_add",  0, 5'd5,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        issue("a_sub",  0, 5'd6,  1, 0, 5'd5, 5'd7, 2'b11, 1, 0, 0);
        bubble("a_b0", 0);
        bubble("a_b1", 0);
        issue("a_add2", 0, 5'd5,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        bubble("a_nop", 0);
        issue("a_or",   0, 5'd8,  1, 0, 5'd5, 5'd5, 2'b11, 2, 2, 0);
        issue("a_w1",   0, 5'd5,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        issue("a_w2",   0, 5'd5,  1, 0, 5'd3, 5'd4, 2'b11, 0, 0, 0);
        issue("a_near", 0, 5'd10, 1, 0, 5'd5, 5'd8, 2'b11, 1, 0, 0);
        bubble("a_b2", 0);
        bubble("a_b3", 0);
        issue("a_far",  0, 5'd11, 1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        bubble("a_b4", 0);
        bubble("a_b5", 0);
        issue("a_beyond", 0, 5'd12, 1, 0, 5'd11, 5'd11, 2'b11, 0, 0, 0);
        bubble("a_b6", 0);
        bubble("a_b7", 0);

        // Load-use
        issue("a_lw",   0, 5'd5,  1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        issue("a_use",  0, 5'd9,  1, 0, 5'd5, 5'd1, 2'b11, 2, 0, 1);
        chk("a_sc_load", 32'(obs_sc), 32'(exp_sc[0]));
        issue("a_lw2",  0, 5'd13, 1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        bubble("a_b8", 0);
        issue("a_use2", 0, 5'd14, 1, 0, 5'd1, 5'd13, 2'b11, 0, 2, 0);

        // x0 and unused sources
        issue("a_wx0",  0, 5'd0,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        issue("a_rx0",  0, 5'd3,  1, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0);
        issue("a_lwx0", 0, 5'd0,  1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        issue("a_rx0b", 0, 5'd3,  1, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0);
        issue("a_lw11", 0, 5'd11, 1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        issue("a_unused", 0, 5'd4, 1, 0, 5'd11, 5'd11, 2'b00, 0, 0, 0);
        chk("a_sc_mid", 32'(obs_sc), 32'(exp_sc[0]));
        bubble("a_b9", 0);
        bubble("a_b10", 0);

        // Flush beats stall and kills the load in EX
        issue("a_lwf", 0, 5'd5, 1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        id_valid    = 1'b1;
        id_rd       = 5'd9;
        id_regwrite = 1'b1;
        id_is_load  = 1'b0;
        id_rs       = {5'd1, 5'd5};
        id_rs_used  = 2'b11;
        flush       = 1'b1;
        @(negedge clk);
        chk("a_flush.stall", 32'(obs_stall), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("a_flush.fwd", 32'(obs_fwd), 32'd0);
        chk("a_flush.sc",  32'(obs_sc),  32'(exp_sc[0]));
        issue("a_refetch", 0, 5'd9, 1, 0, 5'd5, 5'd1, 2'b11, 0, 0, 0);

        // DEPTH=3, LOAD_LAT=3
        issue("b_lw",   1, 5'd5,  1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        issue("b_use",  1, 5'd9,  1, 0, 5'd5, 5'd1, 2'b11, 3, 0, 2);
        chk("b_sc_load", 32'(obs_sc), 32'(exp_sc[1]));
        issue("b_add",  1, 5'd7,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        issue("b_adj",  1, 5'd6,  1, 0, 5'd2, 5'd7, 2'b11, 0, 1, 0);
        issue("b_add2", 1, 5'd8,  1, 0, 5'd1, 5'd2, 2'b11, 0, 0, 0);
        bubble("b_b0", 1);
        bubble("b_b1", 1);
        issue("b_far",  1, 5'd10, 1, 0, 5'd8, 5'd8, 2'b11, 3, 3, 0);
        issue("b_lw2",  1, 5'd14, 1, 1, 5'd2, 5'd0, 2'b01, 0, 0, 0);
        bubble("b_b2", 1);
        issue("b_use2", 1, 5'd15, 1, 0, 5'd14, 5'd1, 2'b11, 3, 0, 1);
        chk("b_sc_total", 32'(obs_sc), 32'(exp_sc[1]));

        // Counter saturation: a self-dependent load chain stalls 14 of every 15 cycles
        tgt         = 2;
        id_valid    = 1'b1;
        id_rd       = 5'd5;
        id_regwrite = 1'b1;
        id_is_load  = 1'b1;
        id_rs       = {5'd0, 5'd5};
        id_rs_used  = 2'b01;
        flush       = 1'b0;
        repeat (75100) @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!obs_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("s_sc_sat",   32'(obs_sc),    32'h0000_FFFF);
        chk("s_stall_hi", 32'(obs_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s_rst.stall", 32'(obs_stall), 32'd0);
        chk("s_rst.fwd",   32'(obs_fwd),   32'd0);
        chk("s_rst.sc",    32'(obs_sc),    32'd0);
        chk("a_rst.sc",    32'(ifa.stall_cycles), 32'd0);
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
